// File: rtl/mac_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mac_job_sequencer_pkg
//   Shared types and constants for the MAC job sequencer.
//   - seq_state_t : sequencer FSM states
//   - ctrl_seq_t  : start pulse plus the engine-mode part of the job config
//   - flags_seq_t : registered busy / done status
//   - seq_lvl()   : converts a loop number into a loop-level index
// -----------------------------------------------------------------------------
package mac_job_sequencer_pkg;

    // Upper bound on the loop nest depth; sets the width of loop-level indices.
    localparam int MAC_SEQ_N_LOOPS_MAX = 4;
    localparam int MAC_SEQ_LVL_W       = $clog2(MAC_SEQ_N_LOOPS_MAX);

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_REQ,
        SEQ_START,
        SEQ_WAIT,
        SEQ_UPDATE
    } seq_state_t;

    typedef struct packed {
        logic       start;
        logic [4:0] shift;
        logic       simplemul;
    } ctrl_seq_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_seq_t;

    function automatic logic [MAC_SEQ_LVL_W-1:0] seq_lvl(input int l);
        return MAC_SEQ_LVL_W'(l);
    endfunction

endpackage

// File: rtl/mac_seq_loop_counter.sv
// -----------------------------------------------------------------------------
// mac_seq_loop_counter
//   Nested loop index counters. Loop 0 is innermost. Reports the lowest loop
//   whose index has not yet reached its trip value (the loop that increments
//   on the next advance) and whether every loop sits on its last value.
//
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous soft clear (all indices to 0)
//   load_i          job start: all indices to 0
//   advance_i       step the nest; ignored when last_o is high
//   trip_i          per-loop trip count minus one, loop l at [l*CNT_WIDTH +:]
//   inc_lvl_o       lowest loop with idx != trip
//   last_o          every loop is on its final iteration
//   idx0_zero_o     innermost index is 0 (first step of an accumulation run)
// -----------------------------------------------------------------------------
module mac_seq_loop_counter
    import mac_job_sequencer_pkg::*;
#(
    parameter int N_LOOPS   = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic                         advance_i,
    input  logic [N_LOOPS*CNT_WIDTH-1:0] trip_i,
    output logic [MAC_SEQ_LVL_W-1:0]     inc_lvl_o,
    output logic                         last_o,
    output logic                         idx0_zero_o
);

    logic [CNT_WIDTH-1:0] idx_q [N_LOOPS];
    logic                 found_d;

    // Priority search from the innermost loop outwards.
    always_comb begin
        // NOTE: every output of this block gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        found_d   = 1'b0;
        inc_lvl_o = '0;
        for (int l = 0; l < N_LOOPS; l++) begin
            if (!found_d && (idx_q[l] != trip_i[l*CNT_WIDTH +: CNT_WIDTH])) begin
                found_d   = 1'b1;
                inc_lvl_o = seq_lvl(l);
            end
        end
        last_o      = !found_d;
        idx0_zero_o = (idx_q[0] == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: idx_q is a few small flop registers, not a RAM, so it is
            // reset like any other state.
            for (int l = 0; l < N_LOOPS; l++) idx_q[l] <= '0;
        end else if (clear_i || load_i) begin
            for (int l = 0; l < N_LOOPS; l++) idx_q[l] <= '0;
        end else if (advance_i && !last_o) begin
            // Loops below the incrementing level wrap back to 0.
            for (int l = 0; l < N_LOOPS; l++) begin
                if (seq_lvl(l) < inc_lvl_o) begin
                    idx_q[l] <= '0;
                end else if (seq_lvl(l) == inc_lvl_o) begin
                    idx_q[l] <= idx_q[l] + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/mac_job_sequencer.sv
// -----------------------------------------------------------------------------
// mac_job_sequencer
//   Hardware loop sequencer for the MAC accelerator. For each innermost
//   iteration of an N_LOOPS-deep nest it issues one address/length request per
//   stream, starts the engine, waits for completion, then advances the nest.
//   A one-cycle done event marks the end of the job.
//
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous soft clear, same effect as reset
//   start_i             job start, accepted only when idle
//   cfg_*_i             job config, sampled on the accepted start
//   strm_valid_o/ready_i, strm_addr_o, strm_len_o   per-stream requests
//   eng_start_o, eng_clear_acc_o, eng_done_i        engine handshake
//   eng_shift_o, eng_simplemul_o                    latched engine mode
//   busy_o, done_evt_o                              status
//
//   Optional: define MAC_JOB_SEQUENCER_PERF_EN to add perf_cycles_o (busy
//   cycles) and perf_stall_o (request cycles with a stalled stream).
// -----------------------------------------------------------------------------
module mac_job_sequencer
    import mac_job_sequencer_pkg::*;
#(
    parameter int N_LOOPS    = 2,
    parameter int N_STREAMS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   clear_i,
    input  logic                                   start_i,
    input  logic [N_STREAMS*ADDR_WIDTH-1:0]        cfg_base_i,
    input  logic [N_LOOPS*N_STREAMS*ADDR_WIDTH-1:0] cfg_stride_i,
    input  logic [N_LOOPS*CNT_WIDTH-1:0]           cfg_trip_i,
    input  logic [CNT_WIDTH-1:0]                   cfg_len_i,
    input  logic [4:0]                             cfg_shift_i,
    input  logic                                   cfg_simplemul_i,
    output logic [N_STREAMS-1:0]                   strm_valid_o,
    input  logic [N_STREAMS-1:0]                   strm_ready_i,
    output logic [N_STREAMS*ADDR_WIDTH-1:0]        strm_addr_o,
    output logic [CNT_WIDTH-1:0]                   strm_len_o,
    output logic                                   eng_start_o,
    output logic                                   eng_clear_acc_o,
    input  logic                                   eng_done_i,
    output logic [4:0]                             eng_shift_o,
    output logic                                   eng_simplemul_o,
    output logic                                   busy_o,
    output logic                                   done_evt_o
`ifdef MAC_JOB_SEQUENCER_PERF_EN
    ,
    output logic [31:0]                            perf_cycles_o,
    output logic [31:0]                            perf_stall_o
`endif
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    seq_state_t                 state_q;
    ctrl_seq_t                  ctrl_d;
    flags_seq_t                 flags_q;
    logic [N_STREAMS-1:0]       valid_q;
    logic [N_STREAMS-1:0]       acc_q;
    logic [N_STREAMS-1:0]       acc_d;
    logic                       all_acc_d;
    logic                       start_acc_d;
    logic                       eng_start_q;
    logic                       clr_acc_q;
    logic [4:0]                 shift_q;
    logic                       simplemul_q;
    logic [CNT_WIDTH-1:0]       len_q;
    logic [N_LOOPS*CNT_WIDTH-1:0] trip_q;
    addr_t                      addr_q   [N_STREAMS];
    addr_t                      addr_d   [N_STREAMS];
    addr_t                      saved_q  [N_LOOPS][N_STREAMS];
    addr_t                      stride_q [N_LOOPS][N_STREAMS];
    logic [MAC_SEQ_LVL_W-1:0]   inc_lvl;
    logic                       loop_last;
    logic                       idx0_zero;

    assign ctrl_d      = '{start: start_i, shift: cfg_shift_i, simplemul: cfg_simplemul_i};
    assign start_acc_d = (state_q == SEQ_IDLE) && ctrl_d.start;

    mac_seq_loop_counter #(
        .N_LOOPS   (N_LOOPS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_loop_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .load_i      (start_acc_d),
        .advance_i   (state_q == SEQ_UPDATE),
        .trip_i      (trip_q),
        .inc_lvl_o   (inc_lvl),
        .last_o      (loop_last),
        .idx0_zero_o (idx0_zero)
    );

    always_comb begin
        // Streams accepted so far, including handshakes completing this cycle.
        acc_d     = acc_q | (valid_q & strm_ready_i);
        all_acc_d = &acc_d;
        // Next address: the saved start address of the incrementing loop plus
        // its stride. Sums wrap at ADDR_WIDTH.
        for (int s = 0; s < N_STREAMS; s++) begin
            addr_d[s] = '0;
            for (int l = 0; l < N_LOOPS; l++) begin
                if (seq_lvl(l) == inc_lvl) addr_d[s] = saved_q[l][s] + stride_q[l][s];
            end
        end
        strm_addr_o = '0;
        for (int s = 0; s < N_STREAMS; s++) strm_addr_o[s*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[s];
    end

    assign strm_valid_o    = valid_q;
    assign strm_len_o      = len_q;
    assign eng_start_o     = eng_start_q;
    assign eng_clear_acc_o = clr_acc_q;
    assign eng_shift_o     = shift_q;
    assign eng_simplemul_o = simplemul_q;
    assign busy_o          = flags_q.busy;
    assign done_evt_o      = flags_q.done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEQ_IDLE;
            flags_q     <= '0;
            valid_q     <= '0;
            acc_q       <= '0;
            eng_start_q <= 1'b0;
            clr_acc_q   <= 1'b0;
            shift_q     <= '0;
            simplemul_q <= 1'b0;
            len_q       <= '0;
            trip_q      <= '0;
            for (int s = 0; s < N_STREAMS; s++) addr_q[s] <= '0;
            for (int l = 0; l < N_LOOPS; l++) begin
                for (int s = 0; s < N_STREAMS; s++) begin
                    saved_q[l][s]  <= '0;
                    stride_q[l][s] <= '0;
                end
            end
        end else if (clear_i) begin
            // Trip, stride and saved addresses are reloaded on every start, so
            // only visible outputs and control state are cleared here.
            state_q     <= SEQ_IDLE;
            flags_q     <= '0;
            valid_q     <= '0;
            acc_q       <= '0;
            eng_start_q <= 1'b0;
            clr_acc_q   <= 1'b0;
            shift_q     <= '0;
            simplemul_q <= 1'b0;
            len_q       <= '0;
            for (int s = 0; s < N_STREAMS; s++) addr_q[s] <= '0;
        end else begin
            eng_start_q  <= 1'b0;
            clr_acc_q    <= 1'b0;
            flags_q.done <= 1'b0;
            unique case (state_q)
                SEQ_IDLE: begin
                    if (ctrl_d.start) begin
                        shift_q      <= ctrl_d.shift;
                        simplemul_q  <= ctrl_d.simplemul;
                        len_q        <= cfg_len_i + CNT_WIDTH'(1);
                        trip_q       <= cfg_trip_i;
                        for (int s = 0; s < N_STREAMS; s++) begin
                            addr_q[s] <= cfg_base_i[s*ADDR_WIDTH +: ADDR_WIDTH];
                            for (int l = 0; l < N_LOOPS; l++) begin
                                saved_q[l][s]  <= cfg_base_i[s*ADDR_WIDTH +: ADDR_WIDTH];
                                stride_q[l][s] <= cfg_stride_i[(l*N_STREAMS+s)*ADDR_WIDTH +: ADDR_WIDTH];
                            end
                        end
                        acc_q        <= '0;
                        valid_q      <= '0;
                        flags_q.busy <= 1'b1;
                        state_q      <= SEQ_REQ;
                    end
                end
                SEQ_REQ: begin
                    // Valid stays up until its own handshake; it drops the
                    // cycle after acceptance.
                    valid_q <= ~acc_d;
                    if (all_acc_d) begin
                        acc_q       <= '0;
                        eng_start_q <= 1'b1;
                        clr_acc_q   <= simplemul_q | idx0_zero;
                        state_q     <= SEQ_START;
                    end else begin
                        acc_q <= acc_d;
                    end
                end
                SEQ_START: begin
                    state_q <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (eng_done_i) state_q <= SEQ_UPDATE;
                end
                SEQ_UPDATE: begin
                    if (loop_last) begin
                        flags_q.done <= 1'b1;
                        flags_q.busy <= 1'b0;
                        state_q      <= SEQ_IDLE;
                    end else begin
                        // Loops at or below the incrementing level restart
                        // from the new address.
                        for (int s = 0; s < N_STREAMS; s++) begin
                            addr_q[s] <= addr_d[s];
                            for (int l = 0; l < N_LOOPS; l++) begin
                                if (seq_lvl(l) <= inc_lvl) saved_q[l][s] <= addr_d[s];
                            end
                        end
                        state_q <= SEQ_REQ;
                    end
                end
                default: begin
                    state_q <= SEQ_IDLE;
                end
            endcase
        end
    end

`ifdef MAC_JOB_SEQUENCER_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stall_q;

    // Both counters restart on an accepted start and freeze once idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else if (clear_i || start_acc_d) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (flags_q.busy) perf_cycles_q <= perf_cycles_q + 32'd1;
            if ((state_q == SEQ_REQ) && |(valid_q & ~strm_ready_i)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_mac_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_job_sequencer
//   Self-checking bench for mac_job_sequencer (N_LOOPS=2, N_STREAMS=4).
//   The reference address for iteration (i1, i0) is base + i0*stride0 +
//   i1*stride1; accumulator clear is expected when simplemul or i0 == 0.
// -----------------------------------------------------------------------------
module tb_mac_job_sequencer;

    localparam int NL = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int CW = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  clear_i = 1'b0;
    logic                  start_i = 1'b0;
    logic [NS*AW-1:0]      cfg_base_i = '0;
    logic [NL*NS*AW-1:0]   cfg_stride_i = '0;
    logic [NL*CW-1:0]      cfg_trip_i = '0;
    logic [CW-1:0]         cfg_len_i = '0;
    logic [4:0]            cfg_shift_i = '0;
    logic                  cfg_simplemul_i = 1'b0;
    logic [NS-1:0]         strm_valid_o;
    logic [NS-1:0]         strm_ready_i = '0;
    logic [NS*AW-1:0]      strm_addr_o;
    logic [CW-1:0]         strm_len_o;
    logic                  eng_start_o;
    logic                  eng_clear_acc_o;
    logic                  eng_done_i = 1'b0;
    logic [4:0]            eng_shift_o;
    logic                  eng_simplemul_o;
    logic                  busy_o;
    logic                  done_evt_o;
`ifdef MAC_JOB_SEQUENCER_PERF_EN
    logic [31:0]           perf_cycles_o;
    logic [31:0]           perf_stall_o;
`endif

    mac_job_sequencer #(
        .N_LOOPS    (NL),
        .N_STREAMS  (NS),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .start_i         (start_i),
        .cfg_base_i      (cfg_base_i),
        .cfg_stride_i    (cfg_stride_i),
        .cfg_trip_i      (cfg_trip_i),
        .cfg_len_i       (cfg_len_i),
        .cfg_shift_i     (cfg_shift_i),
        .cfg_simplemul_i (cfg_simplemul_i),
        .strm_valid_o    (strm_valid_o),
        .strm_ready_i    (strm_ready_i),
        .strm_addr_o     (strm_addr_o),
        .strm_len_o      (strm_len_o),
        .eng_start_o     (eng_start_o),
        .eng_clear_acc_o (eng_clear_acc_o),
        .eng_done_i      (eng_done_i),
        .eng_shift_o     (eng_shift_o),
        .eng_simplemul_o (eng_simplemul_o),
        .busy_o          (busy_o),
        .done_evt_o      (done_evt_o)
`ifdef MAC_JOB_SEQUENCER_PERF_EN
        ,
        .perf_cycles_o   (perf_cycles_o),
        .perf_stall_o    (perf_stall_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference job configuration.
    logic [AW-1:0] m_base   [NS];
    logic [AW-1:0] m_stride [NL][NS];
    int            m_trip   [NL];
    logic [CW-1:0] m_len;
    logic [4:0]    m_shift;
    logic          m_simplemul;
    int            stall_seen;
    int            starts_seen;

    task automatic drive_cfg();
        for (int s = 0; s < NS; s++) cfg_base_i[s*AW +: AW] = m_base[s];
        for (int l = 0; l < NL; l++) begin
            cfg_trip_i[l*CW +: CW] = CW'(m_trip[l]);
            for (int s = 0; s < NS; s++) cfg_stride_i[(l*NS+s)*AW +: AW] = m_stride[l][s];
        end
        cfg_len_i       = m_len;
        cfg_shift_i     = m_shift;
        cfg_simplemul_i = m_simplemul;
    endtask

    // Garbage on the config inputs while a job runs must not matter.
    task automatic scramble_cfg();
        for (int s = 0; s < NS; s++) cfg_base_i[s*AW +: AW] = $urandom;
        for (int i = 0; i < NL*NS; i++) cfg_stride_i[i*AW +: AW] = $urandom;
        cfg_trip_i      = NL*CW'($urandom);
        cfg_len_i       = CW'($urandom);
        cfg_shift_i     = 5'($urandom);
        cfg_simplemul_i = 1'($urandom);
    endtask

    task automatic random_cfg(input int max_trip);
        for (int s = 0; s < NS; s++) begin
            m_base[s] = $urandom;
            for (int l = 0; l < NL; l++) m_stride[l][s] = $urandom;
        end
        for (int l = 0; l < NL; l++) m_trip[l] = $urandom_range(0, max_trip);
        m_len       = CW'($urandom);
        m_shift     = 5'($urandom);
        m_simplemul = 1'($urandom);
    endtask

    // Runs one job and checks every request against the model.
    // ready_mode: 0 always ready, 1 random ready, 2 stream b stalled 5 cycles
    // abort_at:   iteration whose WAIT phase gets a clear_i (-1: none)
    // poke_wait:  pulse start_i during every WAIT
    task automatic run_job(input int ready_mode, input int abort_at, input bit poke_wait);
        int            n_iter, i0, i1, cyc, bstall;
        logic [NS-1:0] got, pend, rdy;
        logic [AW-1:0] exp_addr [NS];
        logic          exp_clr;
        logic [CW-1:0] exp_len;
        n_iter      = (m_trip[0] + 1) * (m_trip[1] + 1);
        exp_len     = m_len + CW'(1);
        stall_seen  = 0;
        starts_seen = 0;
        @(negedge clk_i);
        drive_cfg();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        scramble_cfg();
        n_vec++;
        if (busy_o !== 1'b1 || strm_valid_o !== '0) begin
            n_err++;
            $display("FAIL launch: busy=%b valid=%b, expected busy=1 valid=0", busy_o, strm_valid_o);
        end
        for (int it = 0; it < n_iter; it++) begin
            i0 = it % (m_trip[0] + 1);
            i1 = it / (m_trip[0] + 1);
            for (int s = 0; s < NS; s++) begin
                exp_addr[s] = m_base[s] + AW'(i0) * m_stride[0][s] + AW'(i1) * m_stride[1][s];
            end
            exp_clr = m_simplemul || (i0 == 0);
            got = '0; pend = '0; cyc = 0; bstall = 0;
            forever begin
                case (ready_mode)
                    0: rdy = '1;
                    1: rdy = NS'($urandom);
                    default: begin
                        rdy = '1;
                        if (it == 0 && strm_valid_o[1] && bstall < 5) begin
                            rdy[1] = 1'b0;
                            bstall++;
                        end
                    end
                endcase
                strm_ready_i = rdy;
                n_vec++;
                if ((pend & ~strm_valid_o) != '0 || (got & strm_valid_o) != '0 ||
                    eng_start_o !== 1'b0 || done_evt_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL req_protocol it=%0d: valid=%b pending=%b accepted=%b start=%b done_evt=%b",
                             it, strm_valid_o, pend, got, eng_start_o, done_evt_o);
                end
                if ((strm_valid_o & ~rdy) != '0) stall_seen++;
                for (int s = 0; s < NS; s++) begin
                    if (strm_valid_o[s] && rdy[s]) begin
                        n_vec++;
                        if (strm_addr_o[s*AW +: AW] !== exp_addr[s]) begin
                            n_err++;
                            $display("FAIL addr it=%0d s=%0d: got %h expected %h",
                                     it, s, strm_addr_o[s*AW +: AW], exp_addr[s]);
                        end
                        got[s] = 1'b1;
                    end
                end
                pend = strm_valid_o & ~rdy;
                if (got == '1) break;
                @(negedge clk_i);
                cyc++;
                if (cyc > 100) begin
                    n_err++;
                    $display("FAIL req_timeout it=%0d: accepted=%b expected %b", it, got, {NS{1'b1}});
                    return;
                end
            end
            if (ready_mode == 0 || (ready_mode == 2 && it == 0)) begin
                n_vec++;
                if (cyc !== ((ready_mode == 2) ? 6 : 1)) begin
                    n_err++;
                    $display("FAIL req_latency it=%0d: got %0d cycles expected %0d",
                             it, cyc, (ready_mode == 2) ? 6 : 1);
                end
            end
            @(negedge clk_i);
            n_vec++;
            if (eng_start_o !== 1'b1 || eng_clear_acc_o !== exp_clr || strm_valid_o !== '0) begin
                n_err++;
                $display("FAIL eng_start it=%0d: start=%b clear_acc=%b valid=%b expected 1 %b 0",
                         it, eng_start_o, eng_clear_acc_o, strm_valid_o, exp_clr);
            end
            if (eng_start_o === 1'b1) starts_seen++;
            n_vec++;
            if (eng_shift_o !== m_shift || eng_simplemul_o !== m_simplemul || strm_len_o !== exp_len) begin
                n_err++;
                $display("FAIL latched_cfg it=%0d: shift=%0d simplemul=%b len=%h expected %0d %b %h",
                         it, eng_shift_o, eng_simplemul_o, strm_len_o, m_shift, m_simplemul, exp_len);
            end
            @(negedge clk_i);
            if (abort_at == it) begin
                clear_i = 1'b1;
                @(negedge clk_i);
                clear_i = 1'b0;
                n_vec++;
                if (busy_o !== 1'b0 || strm_valid_o !== '0 || eng_start_o !== 1'b0 || strm_addr_o !== '0) begin
                    n_err++;
                    $display("FAIL abort: busy=%b valid=%b start=%b addr=%h expected all 0",
                             busy_o, strm_valid_o, eng_start_o, strm_addr_o);
                end
                repeat (4) begin
                    @(negedge clk_i);
                    n_vec++;
                    if (done_evt_o !== 1'b0 || busy_o !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort_idle: done_evt=%b busy=%b expected 0 0", done_evt_o, busy_o);
                    end
                end
                return;
            end
            if (poke_wait) begin
                start_i = 1'b1;
                scramble_cfg();
                @(negedge clk_i);
                start_i = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            eng_done_i = 1'b1;
            @(negedge clk_i);
            eng_done_i = 1'b0;
            n_vec++;
            if (done_evt_o !== 1'b0 || busy_o !== 1'b1 || eng_start_o !== 1'b0) begin
                n_err++;
                $display("FAIL update it=%0d: done_evt=%b busy=%b start=%b expected 0 1 0",
                         it, done_evt_o, busy_o, eng_start_o);
            end
            @(negedge clk_i);
            if (it == n_iter - 1) begin
                n_vec++;
                if (done_evt_o !== 1'b1 || busy_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_evt: done_evt=%b busy=%b expected 1 0", done_evt_o, busy_o);
                end
                @(negedge clk_i);
                n_vec++;
                if (done_evt_o !== 1'b0 || starts_seen !== n_iter) begin
                    n_err++;
                    $display("FAIL done_pulse: done_evt=%b starts=%0d expected 0 %0d",
                             done_evt_o, starts_seen, n_iter);
                end
            end else begin
                n_vec++;
                if (done_evt_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL early_done it=%0d: done_evt=%b busy=%b expected 0 1", it, done_evt_o, busy_o);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        n_vec++;
        if (busy_o !== 1'b0 || strm_valid_o !== '0 || eng_start_o !== 1'b0 || eng_clear_acc_o !== 1'b0 ||
            done_evt_o !== 1'b0 || eng_shift_o !== '0 || eng_simplemul_o !== 1'b0 ||
            strm_len_o !== '0 || strm_addr_o !== '0) begin
            n_err++;
            $display("FAIL reset: busy=%b valid=%b start=%b clr=%b done=%b shift=%0d sm=%b len=%h addr=%h expected 0",
                     busy_o, strm_valid_o, eng_start_o, eng_clear_acc_o, done_evt_o,
                     eng_shift_o, eng_simplemul_o, strm_len_o, strm_addr_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_loop();
        random_cfg(0);
        m_simplemul = 1'b0;
        m_trip[0] = 3; m_trip[1] = 0;
        m_base[0] = 32'h0000_1000; m_stride[0][0] = 32'd4;
        run_job(0, -1, 1'b0);
    endtask

    task automatic test_two_loop();
        random_cfg(0);
        m_simplemul = 1'b0;
        m_trip[0] = 1; m_trip[1] = 2;
        for (int s = 0; s < NS; s++) begin
            m_base[s] = '0; m_stride[0][s] = 32'h4; m_stride[1][s] = 32'h100;
        end
        run_job(0, -1, 1'b0);
    endtask

    task automatic test_simplemul();
        random_cfg(0);
        m_simplemul = 1'b1;
        m_trip[0] = 2; m_trip[1] = 0;
        run_job(0, -1, 1'b0);
    endtask

    task automatic test_stall();
        random_cfg(0);
        m_trip[0] = 1; m_trip[1] = 0;
        run_job(2, -1, 1'b0);
        n_vec++;
        if (stall_seen !== 5) begin
            n_err++;
            $display("FAIL stall_cycles: got %0d expected 5", stall_seen);
        end
`ifdef MAC_JOB_SEQUENCER_PERF_EN
        n_vec++;
        if (perf_stall_o !== 32'd5 || perf_cycles_o == 32'd0) begin
            n_err++;
            $display("FAIL perf: stall=%0d cycles=%0d expected stall 5, cycles nonzero", perf_stall_o, perf_cycles_o);
        end
`endif
    endtask

    task automatic test_clear_abort();
        random_cfg(0);
        m_trip[0] = 3; m_trip[1] = 1;
        run_job(1, 2, 1'b0);
        random_cfg(1);
        m_base[0] = 32'h0000_2000;
        run_job(1, -1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        @(negedge clk_i);
        eng_done_i = 1'b1;
        @(negedge clk_i);
        eng_done_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            n_vec++;
            if (busy_o !== 1'b0 || strm_valid_o !== '0 || done_evt_o !== 1'b0) begin
                n_err++;
                $display("FAIL idle_done: busy=%b valid=%b done_evt=%b expected 0", busy_o, strm_valid_o, done_evt_o);
            end
        end
        random_cfg(2);
        run_job(0, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            random_cfg(3);
            run_job(1, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_loop();
        test_two_loop();
        test_simplemul();
        test_stall();
        test_clear_abort();
        test_ignored_inputs();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
